bcd_conv_arbiter: RTL

Shares a single 12-bit binary-to-BCD converter among N_REQ requesters, such as display digit drivers and UART formatters.
- Arbitrates requests round-robin, latches the winner's operand and sequences the converter's start/ready handshake.
- Captures the 16-bit BCD result and returns it to the winning requester with a one-cycle response pulse.
- A watchdog aborts conversions that never complete.

---
 rtl/bcd_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/bcd_conv_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared types, defaults and width helper for the BCD converter arbiter
package bcd_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int BIN_W     = 12;
  localparam int BCD_W     = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting at ptr, with wrap-around
module rr_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  // Wrapped candidates (below ptr) are found first and then overridden by any hit at or above ptr.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one binary-to-BCD converter with a timeout watchdog
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int BIN_W   = bcd_arb_pkg::BIN_W,
  parameter int BCD_W   = bcd_arb_pkg::BCD_W,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BIN_W-1:0] req_bin,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [BCD_W-1:0]       resp_bcd,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   conv_start,
  output logic [BIN_W-1:0]       conv_binary,
  input  logic [BCD_W-1:0]       conv_bcd,
  input  logic                   conv_ready
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int TMR_W = clog2(TIMEOUT);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_rr_ptr, r_gnt_idx, w_winner;
  logic [TMR_W-1:0]   r_timer;
  logic               w_found, w_grant, w_timeout;
  logic [N_REQ-1:0]   r_req_ack, r_resp_valid, w_ack_nxt, w_resp_nxt;
  logic [BCD_W-1:0]   r_resp_bcd, w_bcd_nxt;
  logic               r_resp_err, w_err_nxt;
  logic               r_busy, r_conv_start, w_start_nxt;
  logic [BIN_W-1:0]   r_conv_binary;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  // A converter still showing ready (e.g. after a controller-only reset) must drain before a new grant.
  assign w_grant   = w_found && !conv_ready;
  assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (w_grant) w_next = WAIT;
      WAIT: begin
        if (conv_ready)     w_next = DRAIN;
        else if (w_timeout) w_next = RESP;
      end
      DRAIN:   w_next = RESP;
      RESP:    w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  always_comb begin
    w_ack_nxt   = '0;
    w_resp_nxt  = '0;
    w_start_nxt = r_conv_start;
    w_bcd_nxt   = r_resp_bcd;
    w_err_nxt   = r_resp_err;
    case (r_state)
      ARB: begin
        if (w_grant) begin
          w_ack_nxt[w_winner] = 1'b1;
          w_start_nxt         = 1'b1;
        end
      end
      WAIT: begin
        if (conv_ready) begin
          w_start_nxt = 1'b0;
        end else if (w_timeout) begin
          w_start_nxt            = 1'b0;
          w_resp_nxt[r_gnt_idx]  = 1'b1;
          w_bcd_nxt              = '0;
          w_err_nxt              = 1'b1;
        end
      end
      DRAIN: begin
        w_resp_nxt[r_gnt_idx] = 1'b1;
        w_bcd_nxt             = conv_bcd;
        w_err_nxt             = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr      <= '0;
      r_gnt_idx     <= '0;
      r_timer       <= '0;
      r_conv_binary <= '0;
      r_req_ack     <= '0;
      r_resp_valid  <= '0;
      r_resp_bcd    <= '0;
      r_resp_err    <= 1'b0;
      r_conv_start  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_req_ack    <= w_ack_nxt;
      r_resp_valid <= w_resp_nxt;
      r_resp_bcd   <= w_bcd_nxt;
      r_resp_err   <= w_err_nxt;
      r_conv_start <= w_start_nxt;
      r_busy       <= (w_next != ARB);
      if ((r_state == ARB) && w_grant) begin
        r_conv_binary <= req_bin[int'(w_winner)*BIN_W +: BIN_W];
        r_gnt_idx     <= w_winner;
        r_rr_ptr      <= (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + 1'b1;
        r_timer       <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign req_ack     = r_req_ack;
  assign resp_valid  = r_resp_valid;
  assign resp_bcd    = r_resp_bcd;
  assign resp_err    = r_resp_err;
  assign busy        = r_busy;
  assign conv_start  = r_conv_start;
  assign conv_binary = r_conv_binary;

endmodule
